// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths, types and the zero-register index
package cpu_pkg;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int REG_DATA_WIDTH = 16;
    localparam int REG_NUMBER     = 1 << REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_file_wr_decoder.sv
// rtl/reg_file_wr_decoder.sv - write-port address decoder, one-hot enable or all-zero when idle
module wr_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 1 << ADDR_WIDTH
) (
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    output logic [NUM_REGS-1:0]   wr_en
);

    always_comb begin
        wr_en = '0;
        if (we) begin
            wr_en[waddr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R1W register file, r0 hardwired zero; optional forwarding under REG_FILE_BYPASS_EN
module reg_file #(
    parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = cpu_pkg::REG_DATA_WIDTH,
    parameter int REG_NUMBER     = cpu_pkg::REG_NUMBER
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [REG_DATA_WIDTH-1:0] wdata,
    input  logic [REG_ADDR_WIDTH-1:0] raddr_a,
    input  logic [REG_ADDR_WIDTH-1:0] raddr_b,
    output logic [REG_DATA_WIDTH-1:0] rdata_a,
    output logic [REG_DATA_WIDTH-1:0] rdata_b,
    output logic [REG_NUMBER-1:0]     wr_onehot,
    output logic [7:0]                wr_count
);
    import cpu_pkg::*;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(ZERO_REG);

    logic [REG_NUMBER-1:0]     wr_en;
    logic [REG_DATA_WIDTH-1:0] regs [REG_NUMBER];

    wr_decoder #(
        .ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_REGS   (REG_NUMBER)
    ) u_wr_decoder (
        .we    (we),
        .waddr (waddr),
        .wr_en (wr_en)
    );

    // Entry 0 is only ever reset, so it reads as zero while its write is still counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUMBER; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_NUMBER; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_onehot <= '0;
            wr_count  <= '0;
        end else if (we) begin
            wr_onehot <= wr_en;
            if (wr_count != 8'hFF) begin
                wr_count <= wr_count + 8'd1;
            end
        end
    end

    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
`ifdef REG_FILE_BYPASS_EN
        // Forwarding is gated by rst_n so reads stay zero throughout reset.
        if (rst_n && we && (waddr != ZERO_IDX)) begin
            if (raddr_a == waddr) begin
                rdata_a = wdata;
            end
            if (raddr_b == waddr) begin
                rdata_b = wdata;
            end
        end
`else
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file against an array model
module tb_reg_file;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic [15:0] wr_onehot;
    logic [7:0]  wr_count;

    int vectors;
    int miscompares;

    int m_regs [16];
    int m_count;
    int m_onehot;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .wr_onehot (wr_onehot),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_read(input int ra, input bit w, input int wa, input int wd);
`ifdef REG_FILE_BYPASS_EN
        if (w && wa != 0 && ra == wa) return wd;
`endif
        return m_regs[ra];
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_count  = 0;
        m_onehot = 0;
    endtask

    task automatic model_edge(input bit w, input int wa, input int wd);
        if (w) begin
            m_onehot = 1 << wa;
            if (m_count < 255) m_count++;
            if (wa != 0) m_regs[wa] = wd;
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input bit w, input int wa, input int wd, input int ra, input int rb);
        we      = w;
        waddr   = 4'(wa);
        wdata   = 16'(wd);
        raddr_a = 4'(ra);
        raddr_b = 4'(rb);
        #3;
        check("rdata_a", 32'(rdata_a), 32'(model_read(ra, w, wa, wd)));
        check("rdata_b", 32'(rdata_b), 32'(model_read(rb, w, wa, wd)));
        @(posedge clk);
        #1;
        model_edge(w, wa, wd);
        check("wr_onehot", 32'(wr_onehot), 32'(m_onehot));
        check("wr_count", 32'(wr_count), 32'(m_count));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = 4'd5;
        raddr_b = 4'd15;
        model_reset();
        #1;
        check("reset_rdata_a", 32'(rdata_a), 32'h0);
        check("reset_count", 32'(wr_count), 32'h0);
        check("reset_onehot", 32'(wr_onehot), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-cycle with a write in flight
        cycle(1, 5, 16'hBEEF, 5, 5);
        we = 1'b1; waddr = 4'd6; wdata = 16'h6666; raddr_a = 4'd5; raddr_b = 4'd6;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_rdata_a", 32'(rdata_a), 32'h0);
        check("midrst_rdata_b", 32'(rdata_b), 32'h0);
        check("midrst_count", 32'(wr_count), 32'h0);
        check("midrst_onehot", 32'(wr_onehot), 32'h0);
        @(posedge clk);
        #1;
        check("inrst_count", 32'(wr_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_edge(1, 6, 16'h6666);
        check("first_write_count", 32'(wr_count), 32'h1);
        check("first_write_onehot", 32'(wr_onehot), 32'h0040);

        // Write/read
        cycle(1, 3, 16'h1234, 0, 0);
        cycle(1, 15, 16'hFFFF, 0, 0);
        check("wr_onehot_r15", 32'(wr_onehot), 32'h8000);
        check("wr_count_3", 32'(wr_count), 32'h3);
        cycle(0, 0, 0, 3, 15);
        check("read_r3", 32'(rdata_a), 32'h1234);
        check("read_r15", 32'(rdata_b), 32'hFFFF);

        // Zero register
        cycle(1, 0, 16'hAAAA, 0, 0);
        check("zero_onehot", 32'(wr_onehot), 32'h0001);
        check("zero_count", 32'(wr_count), 32'h4);
        cycle(0, 0, 0, 0, 0);
        check("zero_read", 32'(rdata_a), 32'h0);

        // Collision
        cycle(1, 7, 16'h0011, 0, 0);
        we = 1'b1; waddr = 4'd7; wdata = 16'h0022; raddr_a = 4'd7; raddr_b = 4'd0;
        #3;
`ifdef REG_FILE_BYPASS_EN
        check("collide_same_cycle", 32'(rdata_a), 32'h0022);
`else
        check("collide_same_cycle", 32'(rdata_a), 32'h0011);
`endif
        @(posedge clk);
        #1;
        model_edge(1, 7, 16'h0022);
        cycle(0, 0, 0, 7, 7);
        check("collide_next_cycle", 32'(rdata_a), 32'h0022);

        // Hold
        for (int i = 0; i < 3; i++) cycle(0, 9, 16'h5555, 9, 7);
        check("hold_r9", 32'(rdata_a), 32'h0);
        check("hold_onehot", 32'(wr_onehot), 32'h0080);
        check("hold_count", 32'(wr_count), 32'h6);

        // Randomized mix, including same-address read/write
        for (int i = 0; i < 200; i++) begin
            int wa;
            wa = int'($urandom_range(0, 15));
            cycle(bit'($urandom_range(0, 1)), wa, int'($urandom_range(0, 16'hFFFF)),
                  ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
        end

        // Saturation
        for (int i = 0; i < 300; i++) begin
            cycle(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 16'hFFFF)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        check("sat_count", 32'(wr_count), 32'd255);
        for (int r = 0; r < 16; r++) cycle(0, 0, 0, r, 15 - r);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
